// File: rtl/prm_edge_mask_engine.sv
// Programmable multi-channel edge-mask engine: per-channel care/value cube lists,
// matched against a query code by a LANES-wide time-multiplexed scan.
module prm_edge_mask_engine #(
    parameter  int IN_W   = 15,
    parameter  int CUBES  = 128,
    parameter  int LANES  = 8,
    parameter  int CHAN   = 4,
    localparam int IDX_W  = $clog2(CUBES),
    localparam int CH_W   = $clog2(CHAN),
    localparam int STEP_W = $clog2(CUBES / LANES) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_chan,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [IN_W-1:0]   cfg_care,
    input  logic [IN_W-1:0]   cfg_val,
    input  logic              cfg_en,
    output logic              cfg_ready,
    input  logic              q_valid,
    output logic              q_ready,
    input  logic [IN_W-1:0]   q_code,
    input  logic [CHAN-1:0]   q_chan,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [CHAN-1:0]   r_mask,
    output logic [STEP_W-1:0] r_steps
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t              r_state;
    logic [IN_W-1:0]     r_code;
    logic [CHAN-1:0]     r_sel;
    logic [CHAN-1:0]     r_acc;
    logic [IDX_W-1:0]    r_idx;
    logic [STEP_W-1:0]   r_cnt;

    logic [CHAN-1:0][CUBES-1:0] r_en;
    logic [IN_W-1:0]     r_care [CHAN][CUBES];
    logic [IN_W-1:0]     r_val  [CHAN][CUBES];

    logic                w_idle;
    logic                w_cfg_wr;
    logic [IDX_W-1:0]    w_slot;
    logic [CHAN-1:0]     w_acc_next;
    logic                w_last;

    assign w_idle    = (r_state == S_IDLE);
    assign w_cfg_wr  = cfg_we && w_idle;
    assign cfg_ready = w_idle;
    assign q_ready   = w_idle;
    assign w_last    = (r_idx == IDX_W'(CUBES - LANES));

    // Only the enables need reset; a disabled slot never hits, so its
    // care/value contents are don't-care until written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en <= '0;
        end else if (w_cfg_wr) begin
            r_en[cfg_chan][cfg_idx] <= cfg_en;
        end
    end

    // NOTE: memory arrays are deliberately left without reset so they map to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (w_cfg_wr) begin
            r_care[cfg_chan][cfg_idx] <= cfg_care;
            r_val[cfg_chan][cfg_idx]  <= cfg_val;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_acc_next = r_acc;
        w_slot     = '0;
        for (int c = 0; c < CHAN; c++) begin
            for (int l = 0; l < LANES; l++) begin
                w_slot = r_idx + IDX_W'(l);
                if (r_en[c][w_slot] &&
                    (((r_code ^ r_val[c][w_slot]) & r_care[c][w_slot]) == '0))
                    w_acc_next[c] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_code  <= '0;
            r_sel   <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_mask  <= '0;
            r_steps <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (q_valid) begin
                        r_code <= q_code;
                        r_sel  <= q_chan;
                        r_acc  <= '0;
                        r_idx  <= '0;
                        r_cnt  <= '0;
                        if (q_chan == '0) begin
                            r_mask  <= '0;
                            r_steps <= '0;
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + IDX_W'(LANES);
                    r_cnt <= r_cnt + STEP_W'(1);
                    // Stop as soon as every selected channel is blocked, or at the last group.
                    if (((w_acc_next & r_sel) == r_sel) || w_last) begin
                        r_mask  <= w_acc_next & r_sel;
                        r_steps <= r_cnt + STEP_W'(1);
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (r_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// Directed bench for prm_edge_mask_engine: reset abort, single cube, masking,
// config gating, early exit and backpressure with hand-computed expectations.
module tb_prm_edge_mask_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_chan;
    logic [6:0]  cfg_idx;
    logic [14:0] cfg_care;
    logic [14:0] cfg_val;
    logic        cfg_en;
    logic        cfg_ready;
    logic        q_valid;
    logic        q_ready;
    logic [14:0] q_code;
    logic [3:0]  q_chan;
    logic        r_valid;
    logic        r_ready;
    logic [3:0]  r_mask;
    logic [4:0]  r_steps;

    int n_checks = 0;
    int n_fail   = 0;

    prm_edge_mask_engine dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_idx(cfg_idx),
        .cfg_care(cfg_care), .cfg_val(cfg_val), .cfg_en(cfg_en), .cfg_ready(cfg_ready),
        .q_valid(q_valid), .q_ready(q_ready), .q_code(q_code), .q_chan(q_chan),
        .r_valid(r_valid), .r_ready(r_ready), .r_mask(r_mask), .r_steps(r_steps)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [6:0] idx,
                             input logic [14:0] care, input logic [14:0] val, input logic en);
        @(negedge clk);
        cfg_we = 1'b1; cfg_chan = ch; cfg_idx = idx;
        cfg_care = care; cfg_val = val; cfg_en = en;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic start_query(input logic [14:0] code, input logic [3:0] ch);
        @(negedge clk);
        check("q_ready_before_accept", q_ready, 1);
        q_code = code; q_chan = ch; q_valid = 1'b1;
        @(posedge clk); #1;
        q_valid = 1'b0;
    endtask

    // lat counts cycles after the accept edge: 1 = first cycle after accept.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!r_valid && lat < 40);
    endtask

    task automatic finish_result();
        @(negedge clk);
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
    endtask

    task automatic query(input string tag, input logic [14:0] code, input logic [3:0] ch,
                         input logic [3:0] exp_mask, input logic [4:0] exp_steps, input int exp_lat);
        int lat;
        start_query(code, ch);
        wait_result(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_mask"}, r_mask, exp_mask);
        check({tag, "_steps"}, r_steps, exp_steps);
        finish_result();
    endtask

    initial begin
        int lat;
        int seen;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_chan = '0; cfg_idx = '0; cfg_care = '0;
        cfg_val = '0; cfg_en = 1'b0; q_valid = 1'b0; q_code = '0; q_chan = '0; r_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_q_ready", q_ready, 1);
        check("rst_r_valid", r_valid, 0);
        check("rst_r_mask", r_mask, 0);
        check("rst_r_steps", r_steps, 0);

        // Abort a scan with reset; no result may appear afterwards.
        start_query(15'h0000, 4'hF);
        repeat (5) @(negedge clk);
        check("midscan_q_ready", q_ready, 0);
        rst_n = 1'b0;
        #2;
        check("abort_r_valid_in_reset", r_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_cfg_ready", cfg_ready, 1);
        check("abort_q_ready", q_ready, 1);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (r_valid) seen++;
        end
        check("abort_no_result", seen, 0);
        query("empty", 15'h0000, 4'hF, 4'h0, 5'd16, 17);

        // Single cube in the very last slot of channel 1.
        cfg_write(2'd1, 7'd127, 15'h7FFF, 15'h1234, 1'b1);
        query("single_hit", 15'h1234, 4'h2, 4'h2, 5'd16, 17);
        query("single_miss", 15'h1235, 4'h2, 4'h0, 5'd16, 17);

        // Channel 0 blocks 0x0AAA in slot 50 (group 6 -> exit after 7 steps).
        cfg_write(2'd0, 7'd50, 15'h0FFF, 15'h0AAA, 1'b1);
        query("mask_05", 15'h0AAA, 4'h5, 4'h1, 5'd16, 17);
        query("mask_00", 15'h0AAA, 4'h0, 4'h0, 5'd0, 1);
        query("mask_0F", 15'h0AAA, 4'hF, 4'h1, 5'd16, 17);
        query("ch0_early", 15'h0AAA, 4'h1, 4'h1, 5'd7, 8);

        // A write issued mid-scan must be dropped.
        start_query(15'h0AAA, 4'h4);
        repeat (3) @(negedge clk);
        check("scan_cfg_ready", cfg_ready, 0);
        cfg_we = 1'b1; cfg_chan = 2'd2; cfg_idx = 7'd100;
        cfg_care = 15'h7FFF; cfg_val = 15'h0AAA; cfg_en = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        wait_result(lat);
        check("gated_valid", r_valid, 1);
        check("gated_mask", r_mask, 4'h0);
        check("gated_steps", r_steps, 5'd16);
        finish_result();
        query("gated_stays_out", 15'h0AAA, 4'h4, 4'h0, 5'd16, 17);

        // The same write in IDLE, coinciding with the accept, is seen (slot 100 -> group 12).
        @(negedge clk);
        cfg_we = 1'b1; cfg_chan = 2'd2; cfg_idx = 7'd100;
        cfg_care = 15'h7FFF; cfg_val = 15'h0AAA; cfg_en = 1'b1;
        q_code = 15'h0AAA; q_chan = 4'h4; q_valid = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; q_valid = 1'b0;
        wait_result(lat);
        check("coincide_lat", lat, 14);
        check("coincide_mask", r_mask, 4'h4);
        check("coincide_steps", r_steps, 5'd13);
        finish_result();

        // Catch-all cube in slot 3 on every channel.
        for (int c = 0; c < 4; c++) cfg_write(2'(c), 7'd3, 15'h0000, 15'h0000, 1'b1);
        query("early_F", 15'h5555, 4'hF, 4'hF, 5'd1, 2);
        query("early_2", 15'h7FFF, 4'h2, 4'h2, 5'd1, 2);

        // Backpressure: result must hold for 10 cycles with the block busy.
        start_query(15'h0000, 4'hF);
        wait_result(lat);
        check("bp_lat", lat, 2);
        repeat (10) begin
            check("bp_r_valid", r_valid, 1);
            check("bp_r_mask", r_mask, 4'hF);
            check("bp_r_steps", r_steps, 5'd1);
            check("bp_q_ready", q_ready, 0);
            check("bp_cfg_ready", cfg_ready, 0);
            @(negedge clk);
        end
        finish_result();
        check("bp_release_q_ready", q_ready, 1);
        check("bp_release_r_valid", r_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/prm_edge_mask_engine.md
# prm_edge_mask_engine

Programmable, multi-channel successor to the fixed truth-table obstacle checkers used by the PRM roadmap builder. Each channel holds a run-time-loadable list of cubes, each given as a care/value pair over the discretised edge code. A query code is matched against all cubes of the selected channels by a time-multiplexed scan. The result is returned as one edge_mask bit per channel through a valid/ready handshake. The block sits between the edge-code generator and the roadmap edge-pruning stage.

## Interface
- IN_W, 15: width of the discretised edge code.
- CUBES, 128: cube slots per channel; must be a multiple of LANES.
- LANES, 8: cubes evaluated per channel per cycle.
- CHAN, 4: number of independent obstacle channels.
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous active-low.
- cfg_we  in  1  cube write strobe; takes effect only when cfg_we & cfg_ready.
- cfg_chan  in  clog2(CHAN)  target channel.
- cfg_idx  in  clog2(CUBES)  target cube slot.
- cfg_care  in  IN_W  care mask; 1 = bit compared.
- cfg_val  in  IN_W  required value on cared bits.
- cfg_en  in  1  slot enable written with the cube.
- cfg_ready  out  1  high only in IDLE.
- q_valid  in  1  query valid.
- q_ready  out  1  query accept; high only in IDLE.
- q_code  in  IN_W  edge code to check.
- q_chan  in  CHAN  channel select mask.
- r_valid  out  1  result valid.
- r_ready  in  1  result accept.
- r_mask  out  CHAN  per-channel edge_mask (1 = edge blocked), already ANDed with q_chan.
- r_steps  out  clog2(CUBES/LANES)+1  scan cycles actually used.

## Operation
- Cube hit: en & (((code ^ val) & care) == 0). An enabled cube with care = 0 hits every code.
- Reset clears every slot enable, all state, and all outputs. cfg_ready = q_ready = 1; r_valid = 0; r_mask = 0; r_steps = 0.
- The FSM has three states: IDLE, SCAN, DONE.
- IDLE: on q_valid & q_ready, latch q_code and q_chan. Clear the accumulator and set idx = 0.
  - If q_chan == 0, go to DONE with r_mask = 0 and r_steps = 0.
  - Otherwise go to SCAN.
- A cfg write that coincides with a query acceptance in IDLE is applied first. The query sees the new cube.
- SCAN, each cycle:
  - For every channel c, evaluate slots idx..idx+LANES-1 and compute acc_next[c] = acc[c] | any hit.
  - Update acc = acc_next, idx += LANES, steps += 1.
  - Exit to DONE when (acc_next & sel) == sel (early exit: every selected channel already blocked).
  - Also exit to DONE when idx + LANES == CUBES (last group).
  - Unselected channels are still evaluated but masked from the result.
- DONE: r_valid = 1, with r_mask and r_steps held stable. On r_ready, go to IDLE.
- cfg_we outside IDLE is ignored, with no side effects. Cube storage never changes during a scan.
- Width rules:
  - idx is clog2(CUBES) bits and never wraps inside a scan.
  - steps saturates only by construction, since its maximum is CUBES/LANES.
- Asserting rst_n low mid-SCAN or mid-DONE aborts the query. The result is lost and no r_valid pulse appears after release.

## Timing
- Query accepted at edge 0. SCAN occupies cycles 1..N, where N ≤ CUBES/LANES (16 by default).
- r_valid rises in cycle N+1 (registered). Worst-case latency from accept to r_valid is CUBES/LANES + 1 = 17 cycles.
- Early exit after scan cycle j gives r_valid in cycle j+1 and r_steps = j.
- q_chan == 0 gives r_valid in cycle 1.
- One query in flight. q_ready = 0 from the accept edge until the cycle after the r_valid & r_ready handshake.
- Throughput ≥ 1 query per N+2 cycles.
- r_valid never drops without r_ready. Outputs are held indefinitely under backpressure.
- Cfg write at edge t is visible to a query accepted at edge t or later.

## Test plan
- Reset: drive rst_n low mid-scan, then release. Require cfg_ready = q_ready = 1, r_valid = 0, and no result for the aborted query. A query with code 0x0000 and q_chan = 0xF then gives r_mask = 0 and r_steps = 16.
- Single cube, ch1 slot 127: care = 0x7FFF, val = 0x1234, en = 1. Query 0x1234 with q_chan = 0x2 gives r_mask = 0x2, r_steps = 16, r_valid 17 cycles after accept. Query 0x1235 gives r_mask = 0.
- Early exit: slot 3 with care = 0 on all channels. Query with q_chan = 0xF gives r_mask = 0xF, r_steps = 1, r_valid at cycle 2.
- Masking: ch0 blocks the code, ch2 does not. q_chan = 0x5 gives r_mask = 0x1 and r_steps = 16. q_chan = 0 gives r_mask = 0 with r_valid at cycle 1.
- Config gating: cfg_we during SCAN that enables a matching cube is ignored, and the current result is unaffected. The same write in IDLE, simultaneous with a query accept, is seen by that query.
- Backpressure: hold r_ready = 0 for 10 cycles. Require r_valid, r_mask and r_steps stable, q_ready = 0, and cfg_ready = 0. Raising r_ready returns the block to IDLE on the next cycle.
